// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 normalise/round datapath.
// The internal exponent is 6 bits wide so it can exceed 31 before overflow is encoded.
package fp16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int SUM_W    = 15;
   localparam int FRAC_W   = 10;
   localparam int EXP_W    = 6;
   localparam int EXP_BIAS = 15;
   localparam int EXP_MAX  = 2 * EXP_BIAS + 1;

   // A non-zero sum reaches H after at most 13 left shifts (bit 0 up to bit 13).
   localparam logic [3:0] SHIFT_MAX = 4'd13;

   localparam logic [14:0] FP16_INF_MAG  = 15'h7C00;
   localparam logic [14:0] FP16_ZERO_MAG = 15'h0000;

   function automatic logic [15:0] fp16_pack(input logic       sign,
                                             input logic [4:0] exp_field,
                                             input logic [9:0] frac);
      return {sign, exp_field, frac};
   endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even of the {H,F} significand using the guard, round and sticky bits.
// Purely combinational; the carry flags a wrap of {H,F} from all-ones to zero.
module fp16_round_rne
   import fp16_pkg::*;
(
   input  logic [FRAC_W:0] hf_in,
   input  logic            g,
   input  logic            r,
   input  logic            s,
   output logic [FRAC_W:0] hf_out,
   output logic            carry,
   output logic            inexact
);

   logic              inc;
   logic [FRAC_W+1:0] hf_sum;

   assign inc     = g & (r | s | hf_in[0]);
   assign hf_sum  = {1'b0, hf_in} + {{(FRAC_W+1){1'b0}}, inc};
   assign hf_out  = hf_sum[FRAC_W:0];
   assign carry   = hf_sum[FRAC_W+1];
   assign inexact = g | r | s;

endmodule

// File: rtl/fp16_norm_round.sv
// Normalises a raw fp16 mantissa sum one bit per cycle, then rounds and packs it to binary16.
// Handshake: out_ready while idle, out_valid held with the result until in_ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for in_valid; operands captured on accept
// ST_NORM  | one right shift on carry, or one left shift per cycle
// ST_ROUND | RNE rounding, special-case encoding, result registered
// ST_DONE  | result presented until downstream takes it
module fp16_norm_round
   import fp16_pkg::*;
(
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             in_valid,
   output logic             out_ready,
   input  logic [SUM_W-1:0] in_mant_sum,
   input  logic [4:0]       in_exp,
   input  logic             in_sign,
   output logic             out_valid,
   input  logic             in_ready,
   output logic [15:0]      out_result,
   output logic             out_ovf,
   output logic             out_inexact
);

   state_t             state_q;
   state_t             state_d;

   logic [SUM_W-1:0]   sum_q;
   logic [EXP_W-1:0]   exp_q;
   logic               sign_q;
   logic [3:0]         shift_cnt_q;
   logic [15:0]        result_q;
   logic               ovf_q;
   logic               inexact_q;

   logic               bit_c;
   logic               bit_h;
   logic               sum_zero;
   logic               exp_one;
   logic               norm_stop;

   logic [FRAC_W:0]    hf_rnd;
   logic               rnd_carry;
   logic               rnd_inexact;
   logic [EXP_W-1:0]   exp_rnd;
   logic [FRAC_W:0]    hf_fin;
   logic [4:0]         exp_field;
   logic [15:0]        result_d;
   logic               ovf_d;
   logic               inexact_d;

   assign bit_c     = sum_q[SUM_W-1];
   assign bit_h     = sum_q[SUM_W-2];
   assign sum_zero  = (sum_q == '0);
   assign exp_one   = (exp_q == EXP_W'(1));
   assign norm_stop = bit_h | sum_zero | exp_one | (shift_cnt_q == 4'd0);

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid)            state_d = ST_NORM;
         ST_NORM:  if (bit_c || norm_stop)  state_d = ST_ROUND;
         ST_ROUND:                          state_d = ST_DONE;
         ST_DONE:  if (in_ready)            state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_ready = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   fp16_round_rne u_round (
      .hf_in   (sum_q[SUM_W-2:3]),
      .g       (sum_q[2]),
      .r       (sum_q[1]),
      .s       (sum_q[0]),
      .hf_out  (hf_rnd),
      .carry   (rnd_carry),
      .inexact (rnd_inexact)
   );

   // A subnormal that rounds up into H naturally reports field 1 through exp_q == 1.
   always_comb begin
      exp_rnd   = exp_q + {{(EXP_W-1){1'b0}}, rnd_carry};
      hf_fin    = rnd_carry ? {1'b1, {FRAC_W{1'b0}}} : hf_rnd;
      exp_field = (exp_rnd == EXP_W'(1) && !hf_fin[FRAC_W]) ? 5'd0 : exp_rnd[4:0];
      result_d  = fp16_pack(sign_q, exp_field, hf_fin[FRAC_W-1:0]);
      ovf_d     = 1'b0;
      inexact_d = rnd_inexact;
      if (sum_zero) begin
         result_d  = {sign_q, FP16_ZERO_MAG};
         inexact_d = 1'b0;
      end else if (exp_rnd >= EXP_W'(EXP_MAX)) begin
         result_d  = {sign_q, FP16_INF_MAG};
         ovf_d     = 1'b1;
         inexact_d = 1'b1;
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         sum_q       <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         shift_cnt_q <= 4'd0;
         result_q    <= 16'h0000;
         ovf_q       <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  sum_q       <= in_mant_sum;
                  sign_q      <= in_sign;
                  exp_q       <= (in_exp == 5'd0) ? EXP_W'(1) : {1'b0, in_exp};
                  shift_cnt_q <= SHIFT_MAX;
               end
            end
            ST_NORM: begin
               if (bit_c) begin
                  sum_q <= {1'b0, sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
                  exp_q <= exp_q + EXP_W'(1);
               end else if (!norm_stop) begin
                  sum_q       <= {sum_q[SUM_W-2:0], 1'b0};
                  exp_q       <= exp_q - EXP_W'(1);
                  shift_cnt_q <= shift_cnt_q - 4'd1;
               end
            end
            ST_ROUND: begin
               result_q  <= result_d;
               ovf_q     <= ovf_d;
               inexact_q <= inexact_d;
            end
            default: begin
            end
         endcase
      end
   end

   assign out_result  = result_q;
   assign out_ovf     = ovf_q;
   assign out_inexact = inexact_q;

endmodule

// File: doc/fp16_norm_round.md
FP16_NORM_ROUND -- requirements
Module: fp16_norm_round

Interface
REQ-001 SHALL have port IN_CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port IN_RST_N  input  1  asynchronous active-low reset.
REQ-003 SHALL have port IN_VALID  input  1  upstream presents a mantissa sum.
REQ-004 SHALL have port OUT_READY  output  1  block can accept; high only in IDLE.
REQ-005 SHALL have port IN_MANT_SUM  input  15  raw adder sum {C, H, F[9:0], G, R, S}.
REQ-006 SHALL have port IN_EXP  input  5  biased exponent of the aligned operands; 0 is treated as 1 (subnormal).
REQ-007 SHALL have port IN_SIGN  input  1  result sign.
REQ-008 SHALL have port OUT_VALID  output  1  result available.
REQ-009 SHALL have port IN_READY  input  1  downstream accepts the result.
REQ-010 SHALL have port OUT_RESULT  output  16  IEEE-754 binary16 result.
REQ-011 SHALL have ports OUT_OVF and OUT_INEXACT  output  1 each  overflow flag and inexact flag, valid with OUT_VALID.

Function
REQ-012 SHALL implement FSM IDLE -> NORM -> ROUND -> DONE -> IDLE.
REQ-013 IDLE: IN_VALID high at an edge SHALL register sum, sign, and 6-bit exponent, then go to NORM.
REQ-014 NORM, C=1: SHALL shift right 1, OR the shifted-out bit into S, exp+1, then go to ROUND.
REQ-015 NORM, C=0 and H=1, or sum==0, or exp==1: SHALL go to ROUND.
REQ-016 NORM, otherwise: SHALL shift left 1 with 0 in, exp-1, and stay in NORM; exactly one bit per cycle, at most 13 iterations.
REQ-017 ROUND SHALL apply round-to-nearest-even on G,R,S: increment F when G & (R|S|F[0]).
REQ-018 A round carry out of {H,F} SHALL set H, clear F, and exp+1.
REQ-019 An exp of 1 with H=0 after rounding SHALL encode exponent field 0 (subnormal); a subnormal rounding up to H=1 SHALL encode field 1.
REQ-020 exp>=31 SHALL produce {sign,5'h1F,10'h0} with OUT_OVF=1 and OUT_INEXACT=1.
REQ-021 sum==0 SHALL produce {sign,15'h0} with both flags 0.
REQ-022 OUT_INEXACT SHALL be G|R|S after normalization, plus REQ-020.
REQ-023 ROUND SHALL register OUT_RESULT and the flags, then go to DONE.
REQ-024 DONE: OUT_VALID=1; all outputs SHALL hold stable until IN_READY=1 at an edge, then go to IDLE.
REQ-025 Latency: OUT_VALID SHALL rise 3 edges after the accepting edge with zero shifts, plus 1 edge per left shift.
REQ-026 Input SHALL NOT be accepted outside IDLE; IN_VALID there SHALL be ignored.

Reset
REQ-027 IN_RST_N low SHALL immediately force IDLE, OUT_VALID=0, OUT_READY=1, OUT_RESULT=16'h0, OUT_OVF=0, OUT_INEXACT=0, and all internal registers 0.
REQ-028 Reset mid-NORM or mid-DONE SHALL discard the operation; the first edge after release SHALL be able to accept.

Structure
REQ-029 Shared package fp16_pkg SHALL hold: FSM state encoding, EXP_BIAS=15, EXP_MAX=31, SUM_W=15, the INF and zero constants.
REQ-030 Rounding logic SHALL be sub-module fp16_round_rne (combinational: {H,F,G,R,S} in; rounded {H,F} and carry out).

Verification
REQ-031 Bench SHALL cover: sum 0x2000, exp 15, sign 0 -> 0x3C00, flags 0, OUT_VALID 3 edges after accept.
REQ-032 Bench SHALL cover: sum 0x4000, exp 15 -> 0x4000; sum 0x7FFF, exp 30 -> 0x7C00, OUT_OVF=1.
REQ-033 Bench SHALL cover: sum 0x0400, exp 15 -> 0x3000 after 3 NORM shift cycles (latency 6); sum 0x0001, exp 1 -> 0x0000, OUT_INEXACT=1.
REQ-034 Bench SHALL cover RNE ties: sum 0x2004 -> 0x3C00, OUT_INEXACT=1; sum 0x200C -> 0x3C02; sum 0x3FFC, exp 15 -> 0x4000.
REQ-035 Bench SHALL cover: sum 0, sign 1 -> 0x8000, flags 0; IN_VALID held in DONE -> no second accept.
REQ-036 Bench SHALL cover: IN_READY low 5 cycles -> result and flags stable; IN_RST_N pulsed mid-NORM -> outputs 0, OUT_READY=1, next operation correct.
